tmds_decoder: RTL and testbench

Receive-side counterpart of the HDMI/DVI TMDS encoder. Takes one channel's 10-bit parallel characters from the deserializer, which may be bit-misaligned. Finds word alignment by hunting for control tokens, then decodes each aligned character back to 8-bit video data or a 2-bit control value with a video-enable flag. One instance per colour channel, clocked by the recovered pixel clock.

---
 rtl/tmds_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_tmds_decoder.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder.sv
// tmds_decoder: receive-side TMDS character aligner and decoder for one colour channel.
//
// The deserializer delivers 10-bit characters that may be bit-slipped relative to the
// true character boundary. A 20-bit window of the current and previous word is sliced
// at a candidate offset. While searching, each offset is tried for SEARCH_CYCLES cycles
// and lock is declared after LOCK_TOKENS consecutive control tokens at that offset.
// Once locked, every aligned character is decoded as either a control token or an 8-bit
// video byte. If no control token is seen for TIMEOUT_CYCLES cycles, lock is dropped and
// the search resumes from the current offset.
//
// Ports:
//   clk_in          recovered pixel clock
//   rst_n_in        synchronous active-low reset
//   tmds_in[9:0]    raw deserialized character, bit 0 earliest on the wire
//   data_out[7:0]   decoded video byte (valid when ve_out = 1)
//   control_out[1:0] last decoded control value {c1,c0}
//   ve_out          1 = video data, 0 = control period (or not locked)
//   locked_out      word alignment lock
//   offset_out[3:0] bit offset used to slice the window, 0..9
//   relock_cnt_out[15:0] (only with TMDS_DEC_STATS_EN) saturating count of lock losses
//
// Build option: define TMDS_DEC_STATS_EN to add the relock statistics counter and port.

module tmds_decoder #(
  parameter int unsigned LOCK_TOKENS    = 8,
  parameter int unsigned SEARCH_CYCLES  = 64,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [9:0]  tmds_in,
  output logic [7:0]  data_out,
  output logic [1:0]  control_out,
  output logic        ve_out,
  output logic        locked_out,
  output logic [3:0]  offset_out
`ifdef TMDS_DEC_STATS_EN
  ,
  output logic [15:0] relock_cnt_out
`endif
);

  // Counter widths hold their terminal parameter value.
  localparam int unsigned DwellW = $clog2(SEARCH_CYCLES + 1);
  localparam int unsigned HitsW  = $clog2(LOCK_TOKENS + 1);
  localparam int unsigned SinceW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DwellW-1:0] DwellLast = DwellW'(SEARCH_CYCLES - 1);
  localparam logic [DwellW-1:0] DwellOne  = DwellW'(1);
  localparam logic [HitsW-1:0]  HitsLock  = HitsW'(LOCK_TOKENS);
  localparam logic [HitsW-1:0]  HitsOne   = HitsW'(1);
  localparam logic [SinceW-1:0] SinceLast = SinceW'(TIMEOUT_CYCLES - 1);
  localparam logic [SinceW-1:0] SinceOne  = SinceW'(1);

  localparam logic [0:0] StSearch = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  localparam logic [9:0] Tok00 = 10'b1101010100;
  localparam logic [9:0] Tok01 = 10'b0010101011;
  localparam logic [9:0] Tok10 = 10'b0101010100;
  localparam logic [9:0] Tok11 = 10'b1010101011;

  logic [9:0]        prev_q;
  logic [0:0]        state_q, state_d;
  logic [3:0]        offset_q, offset_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [HitsW-1:0]  hits_q, hits_d;
  logic [SinceW-1:0] since_q, since_d;
  logic [7:0]        data_q, data_d;
  logic [1:0]        control_q, control_d;
  logic              ve_q, ve_d;

  logic [19:0] window;
  logic [9:0]  aligned;
  logic        is_tok;
  logic [1:0]  tok_val;
  logic [7:0]  q_bits;
  logic [7:0]  decoded;
  logic [HitsW-1:0] hits_inc;
  logic        timeout;
  logic        live;

  // Earlier word sits in the low half so that bit 0 of the window is the earliest bit.
  assign window  = {tmds_in, prev_q};
  assign aligned = 10'(window >> offset_q);

  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    case (aligned)
      Tok00:   tok_val = 2'b00;
      Tok01:   tok_val = 2'b01;
      Tok10:   tok_val = 2'b10;
      Tok11:   tok_val = 2'b11;
      default: is_tok  = 1'b0;
    endcase
  end

  // Undo the optional inversion (bit 9), then the XOR/XNOR transition chain (bit 8).
  always_comb begin
    q_bits     = aligned[9] ? ~aligned[7:0] : aligned[7:0];
    decoded    = 8'h00;
    decoded[0] = q_bits[0];
    for (int i = 1; i < 8; i++) begin
      decoded[i] = aligned[8] ? (q_bits[i] ^ q_bits[i-1]) : ~(q_bits[i] ^ q_bits[i-1]);
    end
  end

  assign hits_inc = hits_q + HitsOne;

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    dwell_d  = dwell_q;
    hits_d   = hits_q;
    since_d  = since_q;
    timeout  = 1'b0;
    if (state_q == StSearch) begin
      dwell_d = dwell_q + DwellOne;
      hits_d  = is_tok ? hits_inc : '0;
      // Lock takes priority over a dwell expiry in the same cycle.
      if (is_tok && (hits_inc == HitsLock)) begin
        state_d = StLocked;
        since_d = '0;
        dwell_d = '0;
        hits_d  = '0;
      end else if (dwell_q == DwellLast) begin
        offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
        dwell_d  = '0;
        hits_d   = '0;
      end
    end else begin
      if (is_tok) begin
        since_d = '0;
      end else if (since_q == SinceLast) begin
        timeout = 1'b1;
        state_d = StSearch;
        dwell_d = '0;
        hits_d  = '0;
        since_d = '0;
      end else begin
        since_d = since_q + SinceOne;
      end
    end
  end

  // Outputs go live one edge after lock, and are blanked on the timeout edge so that
  // ve_out and locked_out fall together.
  assign live = (state_q == StLocked) && !timeout;

  always_comb begin
    data_d    = 8'h00;
    control_d = 2'b00;
    ve_d      = 1'b0;
    if (live) begin
      control_d = control_q;
      if (is_tok) begin
        control_d = tok_val;
      end else begin
        data_d = decoded;
        ve_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      prev_q    <= '0;
      state_q   <= StSearch;
      offset_q  <= '0;
      dwell_q   <= '0;
      hits_q    <= '0;
      since_q   <= '0;
      data_q    <= '0;
      control_q <= '0;
      ve_q      <= 1'b0;
    end else begin
      prev_q    <= tmds_in;
      state_q   <= state_d;
      offset_q  <= offset_d;
      dwell_q   <= dwell_d;
      hits_q    <= hits_d;
      since_q   <= since_d;
      data_q    <= data_d;
      control_q <= control_d;
      ve_q      <= ve_d;
    end
  end

  assign data_out    = data_q;
  assign control_out = control_q;
  assign ve_out      = ve_q;
  assign locked_out  = (state_q == StLocked);
  assign offset_out  = offset_q;

`ifdef TMDS_DEC_STATS_EN
  logic [15:0] relock_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      relock_q <= '0;
    end else if (timeout && (relock_q != 16'hFFFF)) begin
      relock_q <= relock_q + 16'd1;
    end
  end

  assign relock_cnt_out = relock_q;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder with a behavioural model of alignment and decode.

module tb_tmds_decoder;

  localparam int LOCK    = 8;
  localparam int SEARCH  = 64;
  localparam int TIMEOUT = 4096;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [9:0]  tmds_in = 10'h000;
  logic [7:0]  data_out;
  logic [1:0]  control_out;
  logic        ve_out;
  logic        locked_out;
  logic [3:0]  offset_out;
`ifdef TMDS_DEC_STATS_EN
  logic [15:0] relock_cnt;
`endif

  tmds_decoder #(
    .LOCK_TOKENS   (LOCK),
    .SEARCH_CYCLES (SEARCH),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .tmds_in    (tmds_in),
    .data_out   (data_out),
    .control_out(control_out),
    .ve_out     (ve_out),
    .locked_out (locked_out),
    .offset_out (offset_out)
`ifdef TMDS_DEC_STATS_EN
    ,
    .relock_cnt_out(relock_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  logic [15:0] dut_vec;
  assign dut_vec = {data_out, control_out, ve_out, locked_out, offset_out};

  // Reference model state: plain integers, the bit stream sliced arithmetically.
  int         m_prev = 0;
  int         m_off = 0;
  int         m_dwell = 0;
  int         m_hits = 0;
  int         m_since = 0;
  bit         m_lock = 1'b0;
  logic [7:0] e_data = 8'h00;
  logic [1:0] e_ctrl = 2'b00;
  logic       e_ve = 1'b0;

  function automatic int token_code(input int a);
    case (a)
      'b1101010100: return 0;
      'b0010101011: return 1;
      'b0101010100: return 2;
      'b1010101011: return 3;
      default:      return -1;
    endcase
  endfunction

  // Transmitter stage 1: transition-minimising chain of a byte.
  function automatic int tmds_stage1(input int d, input int xor_mode);
    int q;
    q = d & 1;
    for (int i = 1; i < 8; i++) begin
      int b;
      b = ((q >> (i - 1)) ^ (d >> i)) & 1;
      if (xor_mode == 0) b = b ^ 1;
      q = q | (b << i);
    end
    return q;
  endfunction

  // Decode by searching for the byte the transmitter would have encoded.
  function automatic int decode_char(input int a);
    int q;
    q = ((a >> 9) & 1) != 0 ? (~a & 'hFF) : (a & 'hFF);
    for (int d = 0; d < 256; d++) begin
      if (tmds_stage1(d, (a >> 8) & 1) == q) return d;
    end
    return -1;
  endfunction

  // Word which, repeated, presents character t when sliced at offset k.
  function automatic logic [9:0] skew(input logic [9:0] t, input int k);
    int r;
    r = ((int'(t) << k) | (int'(t) >> (10 - k))) & 'h3FF;
    return 10'(r);
  endfunction

  function automatic logic [15:0] exp_vec();
    return {e_data, e_ctrl, e_ve, m_lock, 4'(m_off)};
  endfunction

  task automatic model_edge(input logic [9:0] v, input logic rst);
    int a;
    int t;
    bit live;
    bit drop;
    if (!rst) begin
      m_prev = 0; m_off = 0; m_dwell = 0; m_hits = 0; m_since = 0; m_lock = 1'b0;
      e_data = 8'h00; e_ctrl = 2'b00; e_ve = 1'b0;
    end else begin
      a    = (((int'(v) << 10) | m_prev) >> m_off) & 'h3FF;
      t    = token_code(a);
      live = m_lock;
      drop = 1'b0;
      if (m_lock) begin
        if (t >= 0) m_since = 0;
        else if (m_since == TIMEOUT - 1) begin
          drop = 1'b1; m_lock = 1'b0; m_dwell = 0; m_hits = 0;
        end else m_since++;
      end else begin
        m_hits = (t >= 0) ? m_hits + 1 : 0;
        if (m_hits == LOCK) begin
          m_lock = 1'b1; m_since = 0;
        end else if (m_dwell == SEARCH - 1) begin
          m_off = (m_off + 1) % 10; m_dwell = 0; m_hits = 0;
        end else m_dwell++;
      end
      if (live && !drop) begin
        if (t >= 0) begin
          e_data = 8'h00; e_ctrl = 2'(t); e_ve = 1'b0;
        end else begin
          e_data = 8'(decode_char(a)); e_ve = 1'b1;
        end
      end else begin
        e_data = 8'h00; e_ctrl = 2'b00; e_ve = 1'b0;
      end
      m_prev = int'(v);
    end
  endtask

  task automatic step(input logic [9:0] v, input logic rst);
    @(negedge clk_in);
    tmds_in  = v;
    rst_n_in = rst;
    @(posedge clk_in);
    model_edge(v, rst);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(10'($urandom), 1'b0);
      checks++;
      if (dut_vec !== 16'h0000) begin
        errors++; $display("FAIL reset_outputs: got %h required 0000", dut_vec);
      end
    end
    // First token reaches the aligned slot one edge after it is driven.
    for (int i = 1; i <= LOCK + 1; i++) begin
      step(TOK00, 1'b1);
      if (i == LOCK) begin
        checks++;
        if (locked_out !== 1'b0) begin
          errors++; $display("FAIL early_lock: got %b required 0", locked_out);
        end
      end
    end
    checks++;
    if (locked_out !== 1'b1 || offset_out !== 4'd0) begin
      errors++; $display("FAIL lock_offset0: got lock=%b off=%0d required 1/0", locked_out, offset_out);
    end
    step(TOK00, 1'b1);
    checks++;
    if (control_out !== 2'b00 || ve_out !== 1'b0 || data_out !== 8'h00) begin
      errors++; $display("FAIL token00_out: got c=%b ve=%b d=%h required 00/0/00",
                         control_out, ve_out, data_out);
    end
  endtask

  task automatic test_decode();
    step(10'h100, 1'b1);
    checks++;
    if (ve_out !== 1'b0) begin
      errors++; $display("FAIL latency: got ve=%b required 0", ve_out);
    end
    step(10'h200, 1'b1);
    checks++;
    if (data_out !== 8'h00 || ve_out !== 1'b1) begin
      errors++; $display("FAIL dec_100: got d=%h ve=%b required 00/1", data_out, ve_out);
    end
    step(TOK01, 1'b1);
    checks++;
    if (data_out !== 8'hFF || ve_out !== 1'b1) begin
      errors++; $display("FAIL dec_200: got d=%h ve=%b required ff/1", data_out, ve_out);
    end
    step(TOK00, 1'b1);
    checks++;
    if (control_out !== 2'b01 || ve_out !== 1'b0 || data_out !== 8'h00) begin
      errors++; $display("FAIL dec_tok01: got c=%b ve=%b d=%h required 01/0/00",
                         control_out, ve_out, data_out);
    end
    for (int i = 0; i < 200; i++) begin
      step(10'($urandom), 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rand_off0 #%0d: got %h required %h", i, dut_vec, exp_vec());
      end
    end
    step(TOK00, 1'b1);
    step(TOK00, 1'b1);
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    for (int i = 0; i < TIMEOUT + 8; i++) begin
      step(10'h100, 1'b1);
      n = i + 1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL timeout_run #%0d: got %h required %h", i, dut_vec, exp_vec());
      end
      if (locked_out !== 1'b1) break;
    end
    // The first data word reaches the slot one edge after being driven.
    checks++;
    if (n != TIMEOUT + 1) begin
      errors++; $display("FAIL timeout_cycle: got %0d required %0d", n, TIMEOUT + 1);
    end
    checks++;
    if (locked_out !== 1'b0 || ve_out !== 1'b0 || offset_out !== 4'd0) begin
      errors++; $display("FAIL timeout_state: got lock=%b ve=%b off=%0d required 0/0/0",
                         locked_out, ve_out, offset_out);
    end
`ifdef TMDS_DEC_STATS_EN
    checks++;
    if (relock_cnt !== 16'd1) begin
      errors++; $display("FAIL relock_cnt: got %0d required 1", relock_cnt);
    end
`endif
  endtask

  task automatic acquire(input logic [9:0] w, input int exp_off, input int exp_n, input string nm);
    int n;
    n = 0;
    for (int i = 0; i < exp_n + 4; i++) begin
      step(w, 1'b1);
      n = i + 1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL %s_run #%0d: got %h required %h", nm, i, dut_vec, exp_vec());
      end
      if (locked_out === 1'b1) break;
    end
    checks++;
    if (locked_out !== 1'b1 || offset_out !== 4'(exp_off) || n != exp_n) begin
      errors++; $display("FAIL %s_lock: got lock=%b off=%0d cyc=%0d required 1/%0d/%0d",
                         nm, locked_out, offset_out, n, exp_off, exp_n);
    end
  endtask

  task automatic test_misalign();
    step(10'h000, 1'b0);
    acquire(skew(TOK11, 3), 3, 3 * SEARCH + LOCK, "misalign");
    step(skew(TOK11, 3), 1'b1);
    checks++;
    if (control_out !== 2'b11 || ve_out !== 1'b0) begin
      errors++; $display("FAIL misalign_ctrl: got c=%b ve=%b required 11/0", control_out, ve_out);
    end
    for (int i = 0; i < 200; i++) begin
      step(10'($urandom), 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rand_off3 #%0d: got %h required %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_midlock();
    checks++;
    if (locked_out !== 1'b1) begin
      errors++; $display("FAIL midlock_pre: got lock=%b required 1", locked_out);
    end
    step(skew(TOK11, 3), 1'b0);
    checks++;
    if (dut_vec !== 16'h0000) begin
      errors++; $display("FAIL midlock_reset: got %h required 0000", dut_vec);
    end
    acquire(skew(TOK11, 3), 3, 3 * SEARCH + LOCK, "relock");
  endtask

  task automatic test_hits_reset();
    step(10'h000, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      step((i == 8) ? 10'h100 : TOK10, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL hits_run #%0d: got %h required %h", i, dut_vec, exp_vec());
      end
      if (i == 16) begin
        checks++;
        if (locked_out !== 1'b0) begin
          errors++; $display("FAIL hits_cleared: got lock=%b required 0", locked_out);
        end
      end
    end
    checks++;
    if (locked_out !== 1'b1 || offset_out !== 4'd0) begin
      errors++; $display("FAIL hits_relock: got lock=%b off=%0d required 1/0", locked_out, offset_out);
    end
  endtask

  task automatic test_wrap9();
    step(10'h000, 1'b0);
    for (int i = 1; i <= 10 * SEARCH; i++) begin
      step(10'h100, 1'b1);
      if (i == 9 * SEARCH) begin
        checks++;
        if (offset_out !== 4'd9) begin
          errors++; $display("FAIL sweep_off9: got %0d required 9", offset_out);
        end
      end
    end
    checks++;
    if (offset_out !== 4'd0 || locked_out !== 1'b0) begin
      errors++; $display("FAIL sweep_wrap: got off=%0d lock=%b required 0/0", offset_out, locked_out);
    end
    step(10'h000, 1'b0);
    acquire(skew(TOK00, 9), 9, 9 * SEARCH + LOCK, "wrap9");
  endtask

  initial begin
    test_reset();
    test_decode();
    test_timeout();
    test_misalign();
    test_reset_midlock();
    test_hits_reset();
    test_wrap9();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
